// File: rtl/bcd_div_pkg.sv
// Shared types and constants for the BCD divider request scheduler.
package bcd_div_pkg;

  localparam int unsigned BCD_DIGITS             = 4;
  localparam int unsigned BCD_W                  = 4 * BCD_DIGITS;
  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_t;

  typedef enum logic [1:0] {
    ERR_OK      = 2'b00,
    ERR_DIV0    = 2'b01,
    ERR_BCD     = 2'b10,
    ERR_TIMEOUT = 2'b11
  } rsp_err_t;

  typedef struct packed {
    rsp_err_t         err;
    logic [BCD_W-1:0] quotient;
    logic [BCD_W-1:0] remainder;
  } div_result_t;

endpackage

// File: rtl/bcd_digit_check.sv
// Flags whether every nibble of a packed BCD word is a legal decimal digit.
module bcd_digit_check
  import bcd_div_pkg::*;
(
  input  logic [BCD_W-1:0] value,
  output logic             digits_ok_c
);

  always_comb begin
    digits_ok_c = 1'b1;
    for (int i = 0; i < int'(BCD_DIGITS); i++) begin
      if (value[4*i +: 4] > 4'd9) digits_ok_c = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_div_scheduler.sv
// Arbitrates two requesters onto one external bcd_divider, checks operands,
// sequences reset/start/wait and returns results on a shared response bus.
module bcd_div_scheduler
  import bcd_div_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int unsigned N_REQ          = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*BCD_W-1:0]   req_dividend,
  input  logic [N_REQ*BCD_W-1:0]   req_divisor,
  output logic [N_REQ-1:0]         req_ready,
  output logic [N_REQ-1:0]         rsp_valid,
  output logic [BCD_W-1:0]         rsp_quotient,
  output logic [BCD_W-1:0]         rsp_remainder,
  output logic [1:0]               rsp_err,
  output logic                     div_rst,
  output logic                     div_start,
  output logic [BCD_W-1:0]         div_dividend,
  output logic [BCD_W-1:0]         div_divisor,
  input  logic [BCD_W-1:0]         div_quotient,
  input  logic [BCD_W-1:0]         div_remainder,
  input  logic                     div_end
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t           state, state_d;
  logic             last_grant, last_grant_d;
  logic             grant, grant_d;
  logic             sel;
  logic [BCD_W-1:0] opa, opa_d, opb, opb_d;
  logic [BCD_W-1:0] in_dvd, in_dvs;
  logic             dvd_ok_c, dvs_ok_c;
  logic [CNT_W-1:0] cnt, cnt_d;
  div_result_t      res, res_d;
  logic [N_REQ-1:0] ready_c;
  logic             timeout_c;

  // Round-robin pick: on contention the requester not served last wins.
  assign sel    = (&req_valid) ? ~last_grant : req_valid[1];
  assign in_dvd = sel ? req_dividend[2*BCD_W-1:BCD_W] : req_dividend[BCD_W-1:0];
  assign in_dvs = sel ? req_divisor[2*BCD_W-1:BCD_W]  : req_divisor[BCD_W-1:0];

  bcd_digit_check u_chk_dvd (.value(in_dvd), .digits_ok_c(dvd_ok_c));
  bcd_digit_check u_chk_dvs (.value(in_dvs), .digits_ok_c(dvs_ok_c));

  always_comb begin
    state_d      = state;
    last_grant_d = last_grant;
    grant_d      = grant;
    opa_d        = opa;
    opb_d        = opb;
    cnt_d        = cnt;
    res_d        = res;
    ready_c      = '0;
    timeout_c    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (|req_valid) begin
          ready_c[sel] = 1'b1;
          last_grant_d = sel;
          grant_d      = sel;
          opa_d        = in_dvd;
          opb_d        = in_dvs;
          cnt_d        = '0;
          // Operand errors bypass the divider entirely.
          if (in_dvs == '0) begin
            res_d   = '{err: ERR_DIV0, quotient: '0, remainder: in_dvd};
            state_d = ST_RESP;
          end else if (!(dvd_ok_c && dvs_ok_c)) begin
            res_d   = '{err: ERR_BCD, quotient: '0, remainder: '0};
            state_d = ST_RESP;
          end else begin
            state_d = ST_CLR;
          end
        end
      end
      ST_CLR:   state_d = ST_ISSUE;
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // A completion on the final cycle still beats the timeout.
        if (div_end) begin
          res_d   = '{err: ERR_OK, quotient: div_quotient, remainder: div_remainder};
          state_d = ST_RESP;
        end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          timeout_c = 1'b1;
          res_d     = '{err: ERR_TIMEOUT, quotient: '0, remainder: '0};
          state_d   = ST_RESP;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      last_grant   <= 1'b1;
      grant        <= 1'b0;
      opa          <= '0;
      opb          <= '0;
      cnt          <= '0;
      res          <= '0;
      rsp_valid    <= '0;
      div_start    <= 1'b0;
      div_dividend <= '0;
      div_divisor  <= '0;
    end else begin
      state        <= state_d;
      last_grant   <= last_grant_d;
      grant        <= grant_d;
      opa          <= opa_d;
      opb          <= opb_d;
      cnt          <= cnt_d;
      res          <= res_d;
      rsp_valid    <= (state_d == ST_RESP) ? (N_REQ'(1) << grant_d) : '0;
      div_start    <= (state_d == ST_ISSUE);
      // Operands are presented to the divider only while it owns the request.
      if (state_d == ST_CLR || state_d == ST_ISSUE || state_d == ST_WAIT) begin
        div_dividend <= opa_d;
        div_divisor  <= opb_d;
      end else begin
        div_dividend <= '0;
        div_divisor  <= '0;
      end
    end
  end

  assign req_ready     = rst ? '0 : ready_c;
  assign div_rst       = rst | (state == ST_CLR) | timeout_c;
  assign rsp_quotient  = res.quotient;
  assign rsp_remainder = res.remainder;
  assign rsp_err       = res.err;

endmodule

// File: tb/tb_bcd_div_scheduler.sv
// Randomized bench for bcd_div_scheduler with a transaction-level timing model
// and a behavioural divider that answers after a chosen latency.
module tb_bcd_div_scheduler;

  localparam int TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [31:0] req_dividend, req_divisor;
  logic [1:0]  req_ready, rsp_valid, rsp_err;
  logic [15:0] rsp_quotient, rsp_remainder;
  logic        div_rst, div_start, div_end;
  logic [15:0] div_dividend, div_divisor, div_quotient, div_remainder;

  always #5 clk = ~clk;

  bcd_div_scheduler #(.TIMEOUT_CYCLES(TIMEOUT), .N_REQ(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_dividend(req_dividend), .req_divisor(req_divisor),
    .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_quotient(rsp_quotient), .rsp_remainder(rsp_remainder), .rsp_err(rsp_err),
    .div_rst(div_rst), .div_start(div_start),
    .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_quotient(div_quotient), .div_remainder(div_remainder), .div_end(div_end)
  );

  int n_tests = 0, n_fail = 0, c = 0;

  // requester stimulus
  bit          pend [2];
  logic [15:0] p_dvd [2], p_dvs [2];
  bit          rand_mode = 0, repend = 0;
  int          dir_lat = 1;

  // reference model: one outstanding transaction plus the held response
  bit          m_busy = 0, m_last = 1, m_g = 0, m_real = 0, m_to = 0;
  int          m_acc = 0, m_rsp = 0, m_lat = 0;
  logic [15:0] m_q, m_r, m_opa, m_opb, h_q = 0, h_r = 0;
  logic [1:0]  m_err, h_err = 0;

  // behavioural divider
  bit          dv_run = 0;
  int          dv_cnt = 0;
  logic [15:0] dv_q, dv_r;

  // observations for literal checks
  int obs_acc = 0, obs_rsp = 0, n_start = 0;
  logic [1:0] obs_rv = 0;
  int grant_log [$];

  function automatic int bcd2int(logic [15:0] b);
    return int'(b[15:12]) * 1000 + int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic logic [15:0] int2bcd(int v);
    logic [15:0] r;
    r = {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    return r;
  endfunction

  function automatic bit is_bcd(logic [15:0] b);
    for (int i = 0; i < 4; i++) if (b[4*i +: 4] > 4'd9) return 0;
    return 1;
  endfunction

  function automatic int pick_lat();
    int k;
    k = $urandom_range(0, 19);
    if (k == 0) return 0;
    if (k == 1) return TIMEOUT;
    if (k == 2) return TIMEOUT - 1;
    return $urandom_range(1, 12);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, c, act, exp);
      if (n_fail == 200) begin
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
      end
    end
  endtask

  task automatic gen(output logic [15:0] a, output logic [15:0] b);
    int k;
    k = $urandom_range(0, 15);
    a = int2bcd($urandom_range(0, 9999));
    b = int2bcd($urandom_range(1, (k < 6) ? 9 : 999));
    if (k == 0) b = 16'h0000;
    else if (k == 1) a[4*$urandom_range(0, 3) +: 4] = 4'($urandom_range(10, 15));
    else if (k == 2) b[4*$urandom_range(0, 3) +: 4] = 4'($urandom_range(10, 15));
  endtask

  task automatic put(int i, logic [15:0] a, logic [15:0] b);
    pend[i]  = 1;
    p_dvd[i] = a;
    p_dvs[i] = b;
  endtask

  // One clock cycle: drive, compare against the model, advance model and divider.
  task automatic step();
    logic [1:0] exp_ready, exp_rv;
    bit ops;
    int d;
    if (dv_run && dv_cnt == 1) begin
      div_end = 1; div_quotient = dv_q; div_remainder = dv_r;
    end else begin
      div_end = !dv_run && ($urandom_range(0, 7) == 0);
      div_quotient = 16'($urandom); div_remainder = 16'($urandom);
    end
    req_valid    = {pend[1], pend[0]};
    req_dividend = {p_dvd[1], p_dvd[0]};
    req_divisor  = {p_dvs[1], p_dvs[0]};
    #1;
    if (req_ready != 2'b00) begin obs_acc = c; grant_log.push_back(int'(req_ready[1])); end
    if (rsp_valid != 2'b00) begin obs_rsp = c; obs_rv = rsp_valid; end
    if (div_start) n_start++;
    exp_ready = 2'b00;
    if (rst) begin
      chk("div_rst_in_reset", div_rst, 1);
      chk("req_ready_in_reset", req_ready, 0);
      m_busy = 0; m_last = 1; h_q = 0; h_r = 0; h_err = 0;
    end else begin
      if (!m_busy && req_valid != 2'b00) begin
        m_g = (req_valid == 2'b11) ? !m_last : req_valid[1];
        m_last = m_g; m_busy = 1; m_acc = c;
        m_opa = p_dvd[m_g]; m_opb = p_dvs[m_g];
        m_real = 0; m_to = 0; m_q = 0; m_r = 0;
        if (m_opb == 16'h0000) begin
          m_err = 2'd1; m_r = m_opa; m_rsp = c + 1;
        end else if (!is_bcd(m_opa) || !is_bcd(m_opb)) begin
          m_err = 2'd2; m_rsp = c + 1;
        end else begin
          m_real = 1;
          m_lat = rand_mode ? pick_lat() : dir_lat;
          if (m_lat >= 1 && m_lat <= TIMEOUT) begin
            m_err = 2'd0;
            m_q = int2bcd(bcd2int(m_opa) / bcd2int(m_opb));
            m_r = int2bcd(bcd2int(m_opa) % bcd2int(m_opb));
            m_rsp = c + 3 + m_lat;
          end else begin
            m_err = 2'd3; m_to = 1; m_rsp = c + 3 + TIMEOUT;
          end
        end
        exp_ready = m_g ? 2'b10 : 2'b01;
        if (!repend) pend[m_g] = 0;
      end
      exp_rv = 2'b00;
      if (m_busy && c == m_rsp) begin
        exp_rv = m_g ? 2'b10 : 2'b01;
        h_q = m_q; h_r = m_r; h_err = m_err;
      end
      ops = m_busy && m_real && c > m_acc && c < m_rsp;
      chk("req_ready", req_ready, exp_ready);
      chk("rsp_valid", rsp_valid, exp_rv);
      chk("rsp_quotient", rsp_quotient, h_q);
      chk("rsp_remainder", rsp_remainder, h_r);
      chk("rsp_err", rsp_err, h_err);
      chk("div_start", div_start, m_busy && m_real && c == m_acc + 2);
      chk("div_rst", div_rst,
          m_busy && m_real && (c == m_acc + 1 || (m_to && c == m_acc + 2 + TIMEOUT)));
      chk("div_dividend", div_dividend, ops ? m_opa : 16'h0000);
      chk("div_divisor", div_divisor, ops ? m_opb : 16'h0000);
      if (m_busy && c == m_rsp) m_busy = 0;
    end
    if (div_rst) dv_run = 0;
    else if (div_start) begin
      dv_run = 1;
      dv_cnt = (m_lat == 0) ? 1000000 : m_lat;
      d = bcd2int(div_divisor);
      dv_q = (d == 0) ? 16'h0000 : int2bcd(bcd2int(div_dividend) / d);
      dv_r = (d == 0) ? 16'h0000 : int2bcd(bcd2int(div_dividend) % d);
    end else if (dv_run) begin
      if (div_end) dv_run = 0; else dv_cnt--;
    end
    if (rand_mode)
      for (int i = 0; i < 2; i++)
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1;
          gen(p_dvd[i], p_dvs[i]);
        end
    @(negedge clk);
    c++;
  endtask

  task automatic drain(int budget);
    int k;
    k = 0;
    while ((pend[0] || pend[1] || m_busy) && k < budget) begin step(); k++; end
    n_tests++;
    if (pend[0] || pend[1] || m_busy) begin
      n_fail++;
      $display("FAIL drain: work still outstanding after %0d cycles", budget);
    end
  endtask

  initial begin
    int s, k, last_rsp;
    rst = 1; req_valid = 0; req_dividend = 0; req_divisor = 0;
    div_end = 0; div_quotient = 0; div_remainder = 0;
    pend[0] = 0; pend[1] = 0;
    p_dvd[0] = 0; p_dvd[1] = 0; p_dvs[0] = 0; p_dvs[1] = 0;
    @(negedge clk);
    step(); step();
    rst = 0;
    step();
    chk("reset_div_rst_low", div_rst, 0);
    chk("reset_rsp_err", rsp_err, 2'b00);

    dir_lat = 5; put(0, 16'h0025, 16'h0004); drain(100);
    chk("div25_q", rsp_quotient, 16'h0006);
    chk("div25_r", rsp_remainder, 16'h0001);
    chk("div25_err", rsp_err, 2'b00);
    chk("div25_port", obs_rv, 2'b01);
    chk("div25_latency", obs_rsp - obs_acc, 8);

    s = n_start; put(1, 16'h0030, 16'h0000); drain(20);
    chk("div0_q", rsp_quotient, 16'h0000);
    chk("div0_r", rsp_remainder, 16'h0030);
    chk("div0_err", rsp_err, 2'b01);
    chk("div0_port", obs_rv, 2'b10);
    chk("div0_latency", obs_rsp - obs_acc, 1);
    chk("div0_no_start", n_start - s, 0);

    put(0, 16'h00A5, 16'h0003); drain(20);
    chk("bcd_q", rsp_quotient, 16'h0000);
    chk("bcd_r", rsp_remainder, 16'h0000);
    chk("bcd_err", rsp_err, 2'b10);
    chk("bcd_latency", obs_rsp - obs_acc, 1);
    chk("bcd_no_start", n_start - s, 0);

    rst = 1; step(); rst = 0;
    grant_log.delete(); dir_lat = 2; repend = 1;
    put(0, 16'h0100, 16'h0003); put(1, 16'h0200, 16'h0007);
    k = 0;
    while (grant_log.size() < 4 && k < 200) begin step(); k++; end
    repend = 0; pend[0] = 0; pend[1] = 0;
    chk("rr_grant_count", grant_log.size(), 4);
    if (grant_log.size() >= 4) begin
      chk("rr_grant0", grant_log[0], 0);
      chk("rr_grant1", grant_log[1], 1);
      chk("rr_grant2", grant_log[2], 0);
      chk("rr_grant3", grant_log[3], 1);
    end
    drain(200);

    dir_lat = 0; put(0, 16'h0099, 16'h0003); drain(200);
    chk("tmo_err", rsp_err, 2'b11);
    chk("tmo_q", rsp_quotient, 16'h0000);
    chk("tmo_r", rsp_remainder, 16'h0000);
    chk("tmo_latency", obs_rsp - obs_acc, 3 + TIMEOUT);
    dir_lat = 4; put(0, 16'h0100, 16'h0007); drain(100);
    chk("post_tmo_q", rsp_quotient, 16'h0014);
    chk("post_tmo_r", rsp_remainder, 16'h0002);
    chk("post_tmo_err", rsp_err, 2'b00);
    chk("post_tmo_latency", obs_rsp - obs_acc, 7);

    dir_lat = TIMEOUT; put(1, 16'h0050, 16'h0007); drain(200);
    chk("edge_end_err", rsp_err, 2'b00);
    chk("edge_end_q", rsp_quotient, 16'h0007);
    chk("edge_end_r", rsp_remainder, 16'h0001);
    chk("edge_end_latency", obs_rsp - obs_acc, 3 + TIMEOUT);

    dir_lat = 0; put(0, 16'h0999, 16'h0003);
    repeat (10) step();
    last_rsp = obs_rsp;
    rst = 1; step(); rst = 0;
    repeat (3) step();
    chk("abort_no_rsp", obs_rsp, last_rsp);
    chk("abort_q_cleared", rsp_quotient, 16'h0000);
    chk("abort_start_low", div_start, 0);
    dir_lat = 6; put(0, 16'h1234, 16'h0012); drain(100);
    chk("fresh_q", rsp_quotient, 16'h0102);
    chk("fresh_r", rsp_remainder, 16'h0010);
    chk("fresh_err", rsp_err, 2'b00);

    rand_mode = 1;
    repeat (4000) step();
    rand_mode = 0; dir_lat = 3;
    drain(400);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_div_scheduler.md
BCD_DIV_SCHEDULER -- requirements
Module: bcd_div_scheduler

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 64, max cycles spent in WAIT before abort.
REQ-002 Parameter: N_REQ, 2, number of requester ports (fixed at 2 for this revision).
REQ-003 clk  in  1  single clock, all logic rising-edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 req_valid  in  2  per-requester request valid.
REQ-006 req_dividend  in  32  packed 4-digit BCD dividends, requester i at [16i+15:16i].
REQ-007 req_divisor  in  32  packed 4-digit BCD divisors, same packing.
REQ-008 req_ready  out  2  one-cycle accept strobe per requester.
REQ-009 rsp_valid  out  2  one-cycle response strobe per requester.
REQ-010 rsp_quotient  out  16  BCD quotient, shared bus, valid with rsp_valid.
REQ-011 rsp_remainder  out  16  BCD remainder, shared bus, valid with rsp_valid.
REQ-012 rsp_err  out  2  00 ok, 01 divide-by-zero, 10 invalid BCD, 11 timeout.
REQ-013 div_rst, div_start  out  1 each  reset/start to the bcd_divider.
REQ-014 div_dividend, div_divisor  out  16 each  operands to the bcd_divider.
REQ-015 div_quotient, div_remainder  in  16 each; div_end  in  1  (divider end_division).

Function
REQ-016 States: IDLE, CLR, ISSUE, WAIT, RESP; one state per cycle except IDLE/WAIT.
REQ-017 IDLE: if any req_valid, grant one requester round-robin; req_ready[g]=1 that cycle; operands latched; next CLR.
REQ-018 Round-robin: on both valid, grant requester != last_grant; last_grant updates on every grant.
REQ-019 Accept-time check: divisor==0 -> err 01; else any nibble of either operand >9 -> err 10; either error goes straight to RESP, no div_rst/div_start.
REQ-020 Error results: err 01 -> quotient 16'h0000, remainder = dividend; err 10 -> quotient and remainder 16'h0000.
REQ-021 CLR: div_rst=1 for exactly one cycle; next ISSUE.
REQ-022 ISSUE: div_start=1 for exactly one cycle; next WAIT.
REQ-023 div_dividend/div_divisor driven from latched operands from CLR through end of WAIT; 0 otherwise.
REQ-024 WAIT: counter increments each cycle; div_end=1 -> capture div_quotient/div_remainder, err 00, next RESP.
REQ-025 WAIT: counter reaches TIMEOUT_CYCLES without div_end -> err 11, results 16'h0000, div_rst=1 that cycle, next RESP.
REQ-026 div_end on the same cycle as timeout: div_end wins (err 00).
REQ-027 div_end outside WAIT is ignored.
REQ-028 RESP: rsp_valid[g]=1 one cycle, rsp_* hold result; next IDLE; no grant in RESP.
REQ-029 rsp_quotient/rsp_remainder/rsp_err hold last value until next RESP.
REQ-030 Minimum accept-to-response latency for a real division: 3 + divider cycles; error short-circuit: 1 cycle (accept cycle N, rsp_valid N+1).
REQ-031 req_valid deasserted after accept has no effect; a requester drops nothing once ready pulses.

Reset
REQ-032 rst: state IDLE, last_grant=1 (requester 0 wins first), counter 0, all outputs 0 except div_rst.
REQ-033 div_rst=1 while rst=1 (combinational OR with CLR/timeout strobes).
REQ-034 rst mid-operation aborts without a response; in-flight request is lost.

Structure
REQ-035 Shared package bcd_div_pkg: state enum, rsp_err codes, BCD_DIGITS=4, default TIMEOUT_CYCLES.
REQ-036 One sub-module: bcd_digit_check (combinational, 16-bit in, 1-bit "all nibbles <=9").
REQ-037 bcd_divider instantiated by the integrating level, not inside this block.

Verification
REQ-038 req0 16'h0025/16'h0004 with real bcd_divider -> rsp_valid[0], quotient 16'h0006, remainder 16'h0001, err 00.
REQ-039 Both valid after reset -> req0 granted first, then req1; both held valid -> grants alternate 0,1,0,1.
REQ-040 req1 16'h0030/16'h0000 -> rsp_valid[1] next cycle, quotient 0, remainder 16'h0030, err 01, div_start never high.
REQ-041 req0 dividend 16'h00A5 -> err 10, results 0, no div_start.
REQ-042 Divider model holding div_end=0 -> err 11 exactly 64 WAIT cycles after ISSUE, div_rst pulse, next request served normally.
REQ-043 rst in WAIT -> next cycle IDLE, no rsp_valid, outputs 0; fresh 16'h1234/16'h0012 -> quotient 16'h0102, remainder 16'h0010.
